// File: rtl/pico_sync.sv
// pico_sync: serial-in register-bank front end, single clock domain.
//
// sclk and serial_in are sampled as asynchronous data through SYNC_STAGES-deep
// synchronisers. Each synchronised sclk rise shifts one bit (MSB first) into a
// DATA_W-bit word. The first word of a transaction is a header. Its MSB
// selects read (1) or write (0), and its low ADDR_W bits give the start
// address. Each later word produces either a write strobe or a read-load
// request, and the address pointer advances after each one. If sclk stays
// idle for TIMEOUT_CYCLES iclk cycles, the transaction ends.
//
// Legal parameter ranges: DATA_W >= 4, ADDR_W <= DATA_W-1,
// TIMEOUT_CYCLES >= 2, SYNC_STAGES >= 2.
//
// Ports
//   iclk               sole clock
//   rstn               asynchronous active-low reset
//   sclk, serial_in    serial clock / data (asynchronous inputs)
//   write_data         last written word, held between writes
//   wr_en              one-cycle write strobe (write_data + pointer valid)
//   rd_req             one-cycle request to load register[pointer] for readout
//   mux_control_signal current address pointer
//   msg_flag           one-cycle pulse per completed word (header included)
//   sclk_stop_rstn     active-low one-cycle pulse on idle timeout
//   busy               transaction in progress
module pico_sync #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 7,
  parameter int ADDR_MAX       = 2**ADDR_W-1,
  parameter int TIMEOUT_CYCLES = 7,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              iclk,
  input  logic              rstn,
  input  logic              sclk,
  input  logic              serial_in,
  output logic [DATA_W-1:0] write_data,
  output logic              wr_en,
  output logic              rd_req,
  output logic [ADDR_W-1:0] mux_control_signal,
  output logic              msg_flag,
  output logic              sclk_stop_rstn,
  output logic              busy
);
  localparam int CNT_W  = $clog2(DATA_W);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W-1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] PTR_MAX  = ADDR_W'(ADDR_MAX);

  typedef enum logic [1:0] {S_HDR, S_WR, S_RD} state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, sin_sync_q, sin_sync_d;
  logic                sclk_prev_q, sclk_prev_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  // Only DATA_W-1 bits are kept: the oldest bit is shifted out when the word completes.
  logic [DATA_W-2:0]   shreg_q, shreg_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_req_q, rd_req_d;
  logic                msg_q, msg_d;
  logic                stop_n_q, stop_n_d;
  // The write pointer advances one cycle after the strobe, so the strobe sees the old address.
  logic                adv_q, adv_d;

  logic                sclk_s, sin_s, rise, busy_w;
  logic [DATA_W-1:0]   word;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
  assign sin_sync_d  = {sin_sync_q[SYNC_STAGES-2:0], serial_in};
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign sin_s       = sin_sync_q[SYNC_STAGES-1];
  assign sclk_prev_d = sclk_s;
  assign rise        = sclk_s & ~sclk_prev_q;
  assign busy_w      = (state_q != S_HDR) || (bit_cnt_q != '0);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    idle_d    = idle_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    wr_en_d   = 1'b0;
    rd_req_d  = 1'b0;
    msg_d     = 1'b0;
    stop_n_d  = 1'b1;
    adv_d     = 1'b0;
    word      = {shreg_q, sin_s};

    if (adv_q) ptr_d = ptr_inc(ptr_q);

    // A rise takes priority over a timeout that would fire on the same edge.
    if (rise) begin
      idle_d  = '0;
      shreg_d = word[DATA_W-2:0];
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        msg_d     = 1'b1;
        case (state_q)
          S_HDR: begin
            ptr_d = word[ADDR_W-1:0];
            if (word[DATA_W-1]) begin
              state_d  = S_RD;
              rd_req_d = 1'b1;
            end else begin
              state_d  = S_WR;
            end
          end
          S_WR: begin
            wdata_d = word;
            wr_en_d = 1'b1;
            adv_d   = 1'b1;
          end
          S_RD: begin
            ptr_d    = ptr_inc(ptr_q);
            rd_req_d = 1'b1;
          end
          default: state_d = S_HDR;
        endcase
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else if (busy_w) begin
      // After a timeout busy drops and idle_q holds, so it cannot re-fire until a new rise.
      if (idle_q == IDLE_MAX) begin
        state_d   = S_HDR;
        bit_cnt_d = '0;
        shreg_d   = '0;
        stop_n_d  = 1'b0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_HDR;
      sclk_sync_q <= '0;
      sin_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      idle_q      <= '0;
      ptr_q       <= '0;
      wdata_q     <= '0;
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      msg_q       <= 1'b0;
      stop_n_q    <= 1'b1;
      adv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      sin_sync_q  <= sin_sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      idle_q      <= idle_d;
      ptr_q       <= ptr_d;
      wdata_q     <= wdata_d;
      wr_en_q     <= wr_en_d;
      rd_req_q    <= rd_req_d;
      msg_q       <= msg_d;
      stop_n_q    <= stop_n_d;
      adv_q       <= adv_d;
    end
  end

  assign write_data         = wdata_q;
  assign wr_en              = wr_en_q;
  assign rd_req             = rd_req_q;
  assign mux_control_signal = ptr_q;
  assign msg_flag           = msg_q;
  assign sclk_stop_rstn     = stop_n_q;
  assign busy               = busy_w;

endmodule

// File: tb/tb_pico_sync.sv
`timescale 1ns/1ps
module tb_pico_sync;
  localparam int DW  = 8;
  localparam int AW  = 7;
  localparam int TMO = 7;
  localparam int SYN = 2;
  localparam int NADDR = 2**AW;

  logic iclk = 0, rstn = 0, sclk = 0, serial_in = 0;
  logic [DW-1:0] write_data;
  logic wr_en, rd_req, msg_flag, stop_n, busy;
  logic [AW-1:0] mux;

  logic sclk2 = 0, sin2 = 0;
  logic [15:0] wd16;
  logic wr16, rd16, msg16, stop16_n, busy16;
  logic [AW-1:0] mux16;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_rise = 0;

  pico_sync #(.DATA_W(DW), .ADDR_W(AW), .ADDR_MAX(NADDR-1), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYN)) u_dut (
    .iclk(iclk), .rstn(rstn), .sclk(sclk), .serial_in(serial_in),
    .write_data(write_data), .wr_en(wr_en), .rd_req(rd_req),
    .mux_control_signal(mux), .msg_flag(msg_flag),
    .sclk_stop_rstn(stop_n), .busy(busy));

  pico_sync #(.DATA_W(16), .ADDR_W(AW), .ADDR_MAX(NADDR-1), .TIMEOUT_CYCLES(3), .SYNC_STAGES(2)) u_dut16 (
    .iclk(iclk), .rstn(rstn), .sclk(sclk2), .serial_in(sin2),
    .write_data(wd16), .wr_en(wr16), .rd_req(rd16),
    .mux_control_signal(mux16), .msg_flag(msg16),
    .sclk_stop_rstn(stop16_n), .busy(busy16));

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  // Event logs, sampled away from the active edge.
  logic [AW+DW-1:0] wr_log[$];
  logic [AW-1:0]    rd_log[$];
  int               stop_log[$];
  int               msg_cnt = 0;
  logic [AW+15:0]   wr16_log[$];
  int               stop16_cnt = 0, rd16_cnt = 0, msg16_cnt = 0;

  always @(negedge iclk) begin
    if (rstn) begin
      if (wr_en)    wr_log.push_back({mux, write_data});
      if (rd_req)   rd_log.push_back(mux);
      if (msg_flag) msg_cnt++;
      if (!stop_n)  stop_log.push_back(cyc);
      if (wr16)     wr16_log.push_back({mux16, wd16});
      if (rd16)     rd16_cnt++;
      if (msg16)    msg16_cnt++;
      if (!stop16_n) stop16_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One serial bit: data set up one cycle before the sclk rise; rise spacing is hi+lo cycles.
  task automatic send_bit(input logic b, input int hi, input int lo);
    serial_in = b;
    @(posedge iclk); #1;
    sclk = 1; last_rise = cyc;
    repeat (hi) @(posedge iclk);
    #1 sclk = 0;
    repeat (lo - 1) @(posedge iclk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int nbits, input int hi, input int lo);
    for (int i = DW - 1; i >= DW - nbits; i--) send_bit(w[i], hi, lo);
  endtask

  task automatic send_word16(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      sin2 = w[i];
      @(posedge iclk); #1;
      sclk2 = 1;
      repeat (2) @(posedge iclk);
      #1 sclk2 = 0;
      @(posedge iclk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 0;
    @(posedge iclk); #1;
    n_cmp++; if (write_data !== 8'h00) begin n_err++; $display("FAIL rst_write_data: got %0h want 0", write_data); end
    n_cmp++; if (mux !== 7'd0) begin n_err++; $display("FAIL rst_ptr: got %0d want 0", mux); end
    n_cmp++; if ({wr_en, rd_req, msg_flag, busy} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {wr_en, rd_req, msg_flag, busy}); end
    n_cmp++; if (stop_n !== 1'b1) begin n_err++; $display("FAIL rst_stop_n: got %b want 1", stop_n); end
    rstn = 1;
    idle(4);
  endtask

  task automatic test_write_burst();
    int bw = wr_log.size(), br = rd_log.size(), bs = stop_log.size(), bm = msg_cnt;
    logic [AW+DW-1:0] e;
    send_word(8'h05, DW, 3, 3);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wb_busy: got %b want 1", busy); end
    send_word(8'hA1, DW, 3, 3);
    send_word(8'hB2, DW, 3, 3);
    idle(25);
    n_cmp++; if (wr_log.size() - bw != 2) begin n_err++; $display("FAIL wb_wr_count: got %0d want 2", wr_log.size() - bw); end
    else begin
      e = wr_log[bw];
      n_cmp++; if (e !== {7'd5, 8'hA1}) begin n_err++; $display("FAIL wb_wr0: got %0h want %0h", e, {7'd5, 8'hA1}); end
      e = wr_log[bw+1];
      n_cmp++; if (e !== {7'd6, 8'hB2}) begin n_err++; $display("FAIL wb_wr1: got %0h want %0h", e, {7'd6, 8'hB2}); end
    end
    n_cmp++; if (rd_log.size() != br) begin n_err++; $display("FAIL wb_no_rd: got %0d want 0", rd_log.size() - br); end
    n_cmp++; if (msg_cnt - bm != 3) begin n_err++; $display("FAIL wb_msg: got %0d want 3", msg_cnt - bm); end
    n_cmp++; if (mux !== 7'd7) begin n_err++; $display("FAIL wb_ptr: got %0d want 7", mux); end
    n_cmp++; if (write_data !== 8'hB2) begin n_err++; $display("FAIL wb_hold: got %0h want b2", write_data); end
    n_cmp++; if (stop_log.size() - bs != 1) begin n_err++; $display("FAIL wb_stop: got %0d want 1", stop_log.size() - bs); end
  endtask

  task automatic test_read_burst();
    int bw = wr_log.size(), br = rd_log.size();
    logic [AW-1:0] a;
    send_word(8'h83, DW, 3, 3);
    send_word(DW'($urandom), DW, 3, 3);
    send_word(DW'($urandom), DW, 3, 3);
    idle(25);
    n_cmp++; if (rd_log.size() - br != 3) begin n_err++; $display("FAIL rb_rd_count: got %0d want 3", rd_log.size() - br); end
    else for (int k = 0; k < 3; k++) begin
      a = rd_log[br+k];
      n_cmp++; if (a !== AW'(3 + k)) begin n_err++; $display("FAIL rb_rd%0d: got %0d want %0d", k, a, 3 + k); end
    end
    n_cmp++; if (wr_log.size() != bw) begin n_err++; $display("FAIL rb_no_wr: got %0d want 0", wr_log.size() - bw); end
    n_cmp++; if (write_data !== 8'hB2) begin n_err++; $display("FAIL rb_hold: got %0h want b2", write_data); end
  endtask

  task automatic test_wrap();
    int bw = wr_log.size();
    logic [AW+DW-1:0] e;
    send_word(8'h7F, DW, 3, 3);
    send_word(8'h11, DW, 3, 3);
    send_word(8'h22, DW, 3, 3);
    idle(25);
    n_cmp++; if (wr_log.size() - bw != 2) begin n_err++; $display("FAIL wrap_count: got %0d want 2", wr_log.size() - bw); end
    else begin
      e = wr_log[bw];
      n_cmp++; if (e !== {7'd127, 8'h11}) begin n_err++; $display("FAIL wrap_wr0: got %0h want %0h", e, {7'd127, 8'h11}); end
      e = wr_log[bw+1];
      n_cmp++; if (e !== {7'd0, 8'h22}) begin n_err++; $display("FAIL wrap_wr1: got %0h want %0h", e, {7'd0, 8'h22}); end
    end
    n_cmp++; if (mux !== 7'd1) begin n_err++; $display("FAIL wrap_ptr: got %0d want 1", mux); end
  endtask

  task automatic test_timeout_partial();
    int bw = wr_log.size(), br = rd_log.size(), bs = stop_log.size(), bm = msg_cnt;
    int lr, lat;
    logic [AW-1:0] a;
    send_word(8'h10, DW, 3, 3);
    send_word(8'hE0, 3, 3, 3);
    lr = last_rise;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL to_busy_pre: got %b want 1", busy); end
    idle(25);
    n_cmp++; if (stop_log.size() - bs != 1) begin n_err++; $display("FAIL to_stop_count: got %0d want 1", stop_log.size() - bs); end
    else begin
      lat = stop_log[bs] - lr;
      n_cmp++; if (lat != SYN + 1 + TMO + 1) begin n_err++; $display("FAIL to_latency: got %0d want %0d", lat, SYN + TMO + 2); end
    end
    n_cmp++; if (wr_log.size() != bw) begin n_err++; $display("FAIL to_no_wr: got %0d want 0", wr_log.size() - bw); end
    n_cmp++; if (msg_cnt - bm != 1) begin n_err++; $display("FAIL to_msg: got %0d want 1", msg_cnt - bm); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_busy_post: got %b want 0", busy); end
    n_cmp++; if (mux !== 7'h10) begin n_err++; $display("FAIL to_ptr_kept: got %0h want 10", mux); end
    // The next 8 bits must be taken as a fresh header (read from 4).
    send_word(8'h84, DW, 3, 3);
    send_word(8'h00, DW, 3, 3);
    idle(25);
    n_cmp++; if (rd_log.size() - br != 2) begin n_err++; $display("FAIL to_new_hdr: got %0d want 2", rd_log.size() - br); end
    else begin
      a = rd_log[br+1];
      n_cmp++; if (a !== 7'd5) begin n_err++; $display("FAIL to_new_rd1: got %0d want 5", a); end
    end
  endtask

  task automatic test_reset_mid_word();
    int bw;
    logic [AW+DW-1:0] e;
    send_word(8'hFF, 5, 3, 3);
    rstn = 0;
    #1;
    n_cmp++; if (write_data !== 8'h00) begin n_err++; $display("FAIL rm_write_data: got %0h want 0", write_data); end
    n_cmp++; if (mux !== 7'd0) begin n_err++; $display("FAIL rm_ptr: got %0d want 0", mux); end
    n_cmp++; if ({wr_en, rd_req, msg_flag, busy, stop_n} !== 5'b00001) begin n_err++; $display("FAIL rm_flags: got %b want 00001", {wr_en, rd_req, msg_flag, busy, stop_n}); end
    idle(3);
    rstn = 1;
    idle(3);
    bw = wr_log.size();
    send_word(8'h05, DW, 3, 3);
    send_word(8'h3C, DW, 3, 3);
    idle(25);
    n_cmp++; if (wr_log.size() - bw != 1) begin n_err++; $display("FAIL rm_wr_count: got %0d want 1", wr_log.size() - bw); end
    else begin
      e = wr_log[bw];
      n_cmp++; if (e !== {7'd5, 8'h3C}) begin n_err++; $display("FAIL rm_wr: got %0h want %0h", e, {7'd5, 8'h3C}); end
    end
  endtask

  // Rise spacing of TMO (idle at TMO-1) and TMO+1 (idle at TMO, rise wins): no timeout either way.
  task automatic test_timeout_boundary();
    int bw = wr_log.size(), bs = stop_log.size();
    logic [AW+DW-1:0] e;
    send_word(8'h02, DW, 4, TMO - 4);
    send_word(8'h5A, DW, 4, TMO - 3);
    n_cmp++; if (stop_log.size() != bs) begin n_err++; $display("FAIL tb_early_stop: got %0d want 0", stop_log.size() - bs); end
    idle(25);
    n_cmp++; if (wr_log.size() - bw != 1) begin n_err++; $display("FAIL tb_wr_count: got %0d want 1", wr_log.size() - bw); end
    else begin
      e = wr_log[bw];
      n_cmp++; if (e !== {7'd2, 8'h5A}) begin n_err++; $display("FAIL tb_wr: got %0h want %0h", e, {7'd2, 8'h5A}); end
    end
    n_cmp++; if (stop_log.size() - bs != 1) begin n_err++; $display("FAIL tb_stop: got %0d want 1", stop_log.size() - bs); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      logic [DW-1:0] hdr, pv;
      logic [DW-1:0] dat[$];
      logic [AW+DW-1:0] e, ew;
      logic [AW-1:0] a;
      int n, pb, bw, br, bs, bm, ewr, erd, ea;
      hdr = DW'($urandom);
      n   = $urandom_range(0, 3);
      pb  = $urandom_range(0, DW - 1);
      pv  = DW'($urandom);
      dat = {};
      for (int k = 0; k < n; k++) dat.push_back(DW'($urandom));
      bw = wr_log.size(); br = rd_log.size(); bs = stop_log.size(); bm = msg_cnt;
      send_word(hdr, DW, 3, 3);
      for (int k = 0; k < n; k++) send_word(dat[k], DW, 3, 3);
      if (pb > 0) send_word(pv, pb, 3, 3);
      idle(25);
      ewr = hdr[DW-1] ? 0 : n;
      erd = hdr[DW-1] ? n + 1 : 0;
      n_cmp++; if (wr_log.size() - bw != ewr) begin n_err++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", t, wr_log.size() - bw, ewr); end
      else for (int k = 0; k < ewr; k++) begin
        ea = (int'(hdr[AW-1:0]) + k) % NADDR;
        ew = {AW'(ea), dat[k]};
        e  = wr_log[bw+k];
        n_cmp++; if (e !== ew) begin n_err++; $display("FAIL rnd%0d_wr%0d: got %0h want %0h", t, k, e, ew); end
      end
      n_cmp++; if (rd_log.size() - br != erd) begin n_err++; $display("FAIL rnd%0d_rd_count: got %0d want %0d", t, rd_log.size() - br, erd); end
      else for (int k = 0; k < erd; k++) begin
        ea = (int'(hdr[AW-1:0]) + k) % NADDR;
        a  = rd_log[br+k];
        n_cmp++; if (a !== AW'(ea)) begin n_err++; $display("FAIL rnd%0d_rd%0d: got %0d want %0d", t, k, a, ea); end
      end
      ea = (int'(hdr[AW-1:0]) + n) % NADDR;
      n_cmp++; if (mux !== AW'(ea)) begin n_err++; $display("FAIL rnd%0d_ptr: got %0d want %0d", t, mux, ea); end
      n_cmp++; if (msg_cnt - bm != n + 1) begin n_err++; $display("FAIL rnd%0d_msg: got %0d want %0d", t, msg_cnt - bm, n + 1); end
      n_cmp++; if (stop_log.size() - bs != 1) begin n_err++; $display("FAIL rnd%0d_stop: got %0d want 1", t, stop_log.size() - bs); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd%0d_busy: got %b want 0", t, busy); end
    end
  endtask

  // DATA_W=16 / TIMEOUT_CYCLES=3 instance; rises every 4 cycles land exactly on idle==3.
  task automatic test_regression16();
    int bw = wr16_log.size(), bs = stop16_cnt, bm = msg16_cnt;
    logic [AW+15:0] e;
    send_word16(16'h0005);
    send_word16(16'h00A1);
    send_word16(16'h00B2);
    n_cmp++; if (stop16_cnt != bs) begin n_err++; $display("FAIL r16_early_stop: got %0d want 0", stop16_cnt - bs); end
    idle(20);
    n_cmp++; if (wr16_log.size() - bw != 2) begin n_err++; $display("FAIL r16_wr_count: got %0d want 2", wr16_log.size() - bw); end
    else begin
      e = wr16_log[bw];
      n_cmp++; if (e !== {7'd5, 16'h00A1}) begin n_err++; $display("FAIL r16_wr0: got %0h want %0h", e, {7'd5, 16'h00A1}); end
      e = wr16_log[bw+1];
      n_cmp++; if (e !== {7'd6, 16'h00B2}) begin n_err++; $display("FAIL r16_wr1: got %0h want %0h", e, {7'd6, 16'h00B2}); end
    end
    n_cmp++; if (mux16 !== 7'd7) begin n_err++; $display("FAIL r16_ptr: got %0d want 7", mux16); end
    n_cmp++; if (wd16 !== 16'h00B2) begin n_err++; $display("FAIL r16_hold: got %0h want b2", wd16); end
    n_cmp++; if (msg16_cnt - bm != 3) begin n_err++; $display("FAIL r16_msg: got %0d want 3", msg16_cnt - bm); end
    n_cmp++; if (stop16_cnt - bs != 1) begin n_err++; $display("FAIL r16_stop: got %0d want 1", stop16_cnt - bs); end
    n_cmp++; if ({busy16, rd16_cnt != 0} !== 2'b00) begin n_err++; $display("FAIL r16_idle: got busy=%b rd=%0d want 0/0", busy16, rd16_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_timeout_partial();
    test_reset_mid_word();
    test_timeout_boundary();
    test_random();
    test_regression16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
